tx_frame_arbiter: RTL and testbench

//  N-channel scheduler for the Ethernet transmit frame-info FIFO. Each producer (hash block,

---
 rtl/tx_frame_arbiter.sv | 105 ++++++++++
 tb/tb_tx_frame_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_arbiter.sv
// Frame-info FIFO scheduler: one-deep request slot per producer channel, drained as
// {channel id, byte total} under round-robin or fixed priority with almost-full backpressure.
module tx_frame_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned LEN_W       = 11,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_start,
  input  logic [NUM_CH*LEN_W-1:0]  req_bytes,
  input  logic                     tf_afull,
  output logic [ID_W+LEN_W-1:0]    tf_data,
  output logic                     tf_wr_en,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DATA_W = ID_W + LEN_W;

  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [LEN_W-1:0]  bytes_q [NUM_CH];
  logic [LEN_W-1:0]  bytes_d [NUM_CH];
  logic [IDX_W-1:0]  last_q, last_d;
  logic [DATA_W-1:0] tf_data_q, tf_data_d;
  logic              tf_wr_en_q, tf_wr_en_d;

  logic              gnt_valid_c;
  logic [IDX_W-1:0]  gnt_idx_c;
  logic [IDX_W-1:0]  scan_idx_c;

  // Grant search: from last+1 with wrap (round-robin) or from ch0 upward (fixed).
  always_comb begin
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    scan_idx_c  = '0;
    if (!tf_afull) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (ROUND_ROBIN != 0) begin
          scan_idx_c = IDX_W'((32'(last_q) + 32'd1 + i) % NUM_CH);
        end else begin
          scan_idx_c = IDX_W'(i);
        end
        if (!gnt_valid_c && pending_q[scan_idx_c]) begin
          gnt_valid_c = 1'b1;
          gnt_idx_c   = scan_idx_c;
        end
      end
    end
  end

  // Per-channel slot: a granted slot is free this cycle, so a same-cycle start reloads it.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    logic granted_c;
    logic free_c;
    assign granted_c  = gnt_valid_c && (gnt_idx_c == IDX_W'(k));
    assign free_c     = !pending_q[k] || granted_c;
    assign pending_d[k] = (pending_q[k] && !granted_c) || req_start[k];
    assign bytes_d[k]   = (req_start[k] && free_c) ? req_bytes[k*LEN_W +: LEN_W] : bytes_q[k];
    assign ovf_d[k]     = (ovf_q[k] && !ovf_clr) || (req_start[k] && !free_c);
  end

  // Registered FIFO write carries the slot contents as they stood at grant time.
  always_comb begin
    last_d     = last_q;
    tf_data_d  = tf_data_q;
    tf_wr_en_d = gnt_valid_c;
    if (gnt_valid_c) begin
      last_d    = gnt_idx_c;
      tf_data_d = {ID_W'(gnt_idx_c), bytes_q[gnt_idx_c]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q  <= '0;
      ovf_q      <= '0;
      last_q     <= IDX_W'(NUM_CH - 1);
      tf_data_q  <= '0;
      tf_wr_en_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        bytes_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      ovf_q      <= ovf_d;
      last_q     <= last_d;
      tf_data_q  <= tf_data_d;
      tf_wr_en_q <= tf_wr_en_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        bytes_q[i] <= bytes_d[i];
      end
    end
  end

  assign tf_data  = tf_data_q;
  assign tf_wr_en = tf_wr_en_q;
  assign pending  = pending_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: a round-robin instance and a fixed-priority instance.
module tb_tx_frame_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_start, req_start_f;
  logic [43:0] req_bytes, req_bytes_f;
  logic        tf_afull;
  logic        ovf_clr;
  logic [12:0] tf_data, tf_data_f;
  logic        tf_wr_en, tf_wr_en_f;
  logic [3:0]  pending, pending_f;
  logic [3:0]  ovf, ovf_f;

  int checks = 0;
  int errors = 0;

  tx_frame_arbiter #(.NUM_CH(4), .LEN_W(11), .ID_W(2), .ROUND_ROBIN(1)) dut (
    .clock(clock), .reset(reset), .req_start(req_start), .req_bytes(req_bytes),
    .tf_afull(tf_afull), .tf_data(tf_data), .tf_wr_en(tf_wr_en), .pending(pending),
    .ovf(ovf), .ovf_clr(ovf_clr));

  tx_frame_arbiter #(.NUM_CH(4), .LEN_W(11), .ID_W(2), .ROUND_ROBIN(0)) dut_fixed (
    .clock(clock), .reset(reset), .req_start(req_start_f), .req_bytes(req_bytes_f),
    .tf_afull(tf_afull), .tf_data(tf_data_f), .tf_wr_en(tf_wr_en_f), .pending(pending_f),
    .ovf(ovf_f), .ovf_clr(ovf_clr));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_bytes(input int ch, input logic [10:0] b);
    req_bytes[ch*11 +: 11] = b;
  endtask

  task automatic do_reset;
    req_start = '0; req_start_f = '0; req_bytes = '0; req_bytes_f = '0;
    tf_afull = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    req_start = '0; req_start_f = '0; req_bytes = '0; req_bytes_f = '0;
    tf_afull = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({pending, ovf, tf_wr_en, tf_data} !== 22'd0) begin
      errors++;
      $display("FAIL reset_rr: pending=%b ovf=%b wr=%b data=%h required all zero", pending, ovf, tf_wr_en, tf_data);
    end
    checks++;
    if ({pending_f, ovf_f, tf_wr_en_f, tf_data_f} !== 22'd0) begin
      errors++;
      $display("FAIL reset_fixed: pending=%b ovf=%b wr=%b data=%h required all zero", pending_f, ovf_f, tf_wr_en_f, tf_data_f);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    req_start = 4'b0010; set_bytes(1, 11'd64);
    tick;
    req_start = '0;
    checks++;
    if (pending !== 4'b0010 || tf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_t1: pending=%b wr=%b required 0010 0", pending, tf_wr_en);
    end
    tick;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd1, 11'd64} || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_t2: wr=%b data=%h pending=%b required 1 %h 0000", tf_wr_en, tf_data, pending, {2'd1, 11'd64});
    end
    tick;
    checks++;
    if (tf_wr_en !== 1'b0 || tf_data !== {2'd1, 11'd64}) begin
      errors++;
      $display("FAIL single_t3: wr=%b data=%h required 0 %h (held)", tf_wr_en, tf_data, {2'd1, 11'd64});
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    req_start = 4'b0101; set_bytes(0, 11'd100); set_bytes(2, 11'd200);
    tick;
    req_start = '0;
    tick;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd0, 11'd100}) begin
      errors++;
      $display("FAIL simul_first: wr=%b data=%h required 1 %h", tf_wr_en, tf_data, {2'd0, 11'd100});
    end
    tick;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd2, 11'd200}) begin
      errors++;
      $display("FAIL simul_second: wr=%b data=%h required 1 %h", tf_wr_en, tf_data, {2'd2, 11'd200});
    end
    tick;
    checks++;
    if (tf_wr_en !== 1'b0 || ovf !== 4'b0000 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL simul_end: wr=%b ovf=%b pending=%b required 0 0000 0000", tf_wr_en, ovf, pending);
    end
  endtask

  task automatic test_arbitration;
    int seq[$];
    int seq_f[$];
    int ch3_f;
    int exp_rr[6];
    int exp_fx[6];
    exp_rr = '{0, 1, 2, 3, 0, 1};
    exp_fx = '{0, 1, 0, 1, 0, 1};
    ch3_f = 0;
    do_reset;
    for (int k = 0; k < 4; k++) begin
      set_bytes(k, 11'(10 + k));
      req_bytes_f[k*11 +: 11] = 11'(20 + k);
    end
    req_start = 4'hF; req_start_f = 4'hF;
    tick;
    for (int c = 0; c < 16; c++) begin
      req_start   = ~pending;
      req_start_f = ~pending_f;
      tick;
      if (tf_wr_en === 1'b1) seq.push_back(int'(tf_data[12:11]));
      if (tf_wr_en_f === 1'b1) begin
        seq_f.push_back(int'(tf_data_f[12:11]));
        if (tf_data_f[12:11] === 2'd3) ch3_f++;
      end
    end
    req_start = '0; req_start_f = '0;
    checks++;
    if (seq.size() < 6 || seq_f.size() < 6) begin
      errors++;
      $display("FAIL arb_count: rr_writes=%0d fixed_writes=%0d required >=6 each", seq.size(), seq_f.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== exp_rr[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got ch%0d required ch%0d", i, seq[i], exp_rr[i]);
        end
        checks++;
        if (seq_f[i] !== exp_fx[i]) begin
          errors++;
          $display("FAIL fixed_order[%0d]: got ch%0d required ch%0d", i, seq_f[i], exp_fx[i]);
        end
      end
    end
    checks++;
    if (ch3_f !== 0) begin
      errors++;
      $display("FAIL fixed_ch3_starved: ch3 grants=%0d required 0", ch3_f);
    end
    checks++;
    if (ovf !== 4'b0000 || ovf_f !== 4'b0000) begin
      errors++;
      $display("FAIL arb_ovf: rr=%b fixed=%b required 0000", ovf, ovf_f);
    end
  endtask

  task automatic test_backpressure;
    int early;
    early = 0;
    do_reset;
    tf_afull = 1'b1;
    req_start = 4'b1000; set_bytes(3, 11'd1500);
    tick;
    req_start = '0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (tf_wr_en !== 1'b0) early++;
    end
    checks++;
    if (early !== 0 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL afull_block: writes=%0d pending=%b required 0 1000", early, pending);
    end
    tf_afull = 1'b0;
    tick;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd3, 11'd1500}) begin
      errors++;
      $display("FAIL afull_release: wr=%b data=%h required 1 %h", tf_wr_en, tf_data, {2'd3, 11'd1500});
    end
  endtask

  task automatic test_overflow;
    do_reset;
    tf_afull = 1'b1;
    req_start = 4'b0100; set_bytes(2, 11'd10);
    tick;
    set_bytes(2, 11'd20);
    tick;
    req_start = '0;
    checks++;
    if (ovf !== 4'b0100 || pending !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b pending=%b required 0100 0100", ovf, pending);
    end
    tf_afull = 1'b0;
    tick;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd2, 11'd10}) begin
      errors++;
      $display("FAIL ovf_keep_old: wr=%b data=%h required 1 %h", tf_wr_en, tf_data, {2'd2, 11'd10});
    end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b required 0000", ovf);
    end
    // Same-cycle clear and fresh overflow: the overflow stays set.
    tf_afull = 1'b1;
    req_start = 4'b0010; set_bytes(1, 11'd5);
    tick;
    tick;
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    req_start = '0;
    checks++;
    if (ovf !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_clr_race: ovf=%b required 0010", ovf);
    end
    tf_afull = 1'b0;
  endtask

  task automatic test_reload;
    do_reset;
    req_start = 4'b0001; set_bytes(0, 11'd5);
    tick;
    set_bytes(0, 11'd7);
    tick;
    req_start = '0;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd0, 11'd5} || pending !== 4'b0001 || ovf !== 4'b0000) begin
      errors++;
      $display("FAIL reload_grant: wr=%b data=%h pending=%b ovf=%b required 1 %h 0001 0000",
               tf_wr_en, tf_data, pending, ovf, {2'd0, 11'd5});
    end
    tick;
    checks++;
    if (tf_wr_en !== 1'b1 || tf_data !== {2'd0, 11'd7}) begin
      errors++;
      $display("FAIL reload_next: wr=%b data=%h required 1 %h", tf_wr_en, tf_data, {2'd0, 11'd7});
    end
  endtask

  task automatic test_reset_midop;
    int late;
    late = 0;
    do_reset;
    req_start = 4'b0010; set_bytes(1, 11'd33);
    tick;
    req_start = '0;
    reset = 1'b1;
    #1;
    checks++;
    if (pending !== 4'b0000 || tf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pending=%b wr=%b required 0000 0", pending, tf_wr_en);
    end
    tick;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (tf_wr_en !== 1'b0) late++;
    end
    checks++;
    if (late !== 0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d pending=%b required 0 0000", late, pending);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_simultaneous;
    test_arbitration;
    test_backpressure;
    test_overflow;
    test_reload;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
